// File: rtl/sd_trace_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : sd_trace_packetizer
//  Purpose  : Turns SD controller status changes into 5-byte timestamped
//             trace packets and streams them out of a byte FIFO.
//  Revision : 1.0  initial release
// ============================================================================

module sd_trace_packetizer #(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             PCLK_i,
    input  logic             PRESET_i,
    input  logic             trace_enable_i,
    input  logic             cmd_busy_i,
    input  logic             data_busy_i,
    input  logic             dma_busy_i,
    input  logic [15:0]      error_status_i,
    input  logic [1:0]       power_state_i,
    output logic [7:0]       trace_data_o,
    output logic             trace_valid_o,
    input  logic             trace_ready_i,
    output logic [7:0]       drop_count_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             busy_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int SNAP_W  = 21;
    localparam int PKT_LEN = 5;

    if (FIFO_DEPTH < 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 8");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_W0   = 3'd1,
        S_W1   = 3'd2,
        S_W2   = 3'd3,
        S_W3   = 3'd4,
        S_W4   = 3'd5
    } state_t;

    state_t              state_q;
    logic [3:0]          seq_q;
    logic [SNAP_W-1:0]   last_snap_q;
    logic [SNAP_W-1:0]   snap_lat_q;
    logic [7:0]          delta_q;
    logic [7:0]          ts_q;
    logic                ovf_q;
    logic                ovf_lat_q;
    logic                force_q;
    logic                en_prev_q;
    logic [7:0]          drop_q;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_q;
    logic [PTR_W-1:0]    rd_q;
    logic [LVL_W-1:0]    level_q;
    logic [LVL_W-1:0]    level_d;

    logic [SNAP_W-1:0]   w_snap;
    logic                w_en_rise;
    logic                w_event;
    logic                w_pop;
    logic                w_push;
    logic [LVL_W-1:0]    w_lvl_after_pop;
    logic                w_room;
    logic [7:0]          w_byte;

    assign w_snap    = {error_status_i, power_state_i, dma_busy_i, data_busy_i, cmd_busy_i};
    assign w_en_rise = trace_enable_i & ~en_prev_q;
    assign w_event   = (state_q == S_IDLE) && trace_enable_i &&
                       ((w_snap != last_snap_q) || force_q || w_en_rise);

    assign w_pop  = (level_q != '0) && trace_ready_i;
    assign w_push = (state_q != S_IDLE);

    // Space check counts the byte leaving on this same edge; a whole packet is
    // reserved up front so the builder never has to stall on a full FIFO.
    assign w_lvl_after_pop = level_q - LVL_W'(w_pop);
    assign w_room          = (w_lvl_after_pop <= LVL_W'(FIFO_DEPTH - PKT_LEN));

    always_comb begin
        w_byte = 8'h00;
        unique case (state_q)
            S_W0:    w_byte = {4'hA, seq_q};
            S_W1:    w_byte = {ovf_lat_q, 2'b00, snap_lat_q[4:0]};
            S_W2:    w_byte = snap_lat_q[20:13];
            S_W3:    w_byte = snap_lat_q[12:5];
            S_W4:    w_byte = ts_q;
            default: w_byte = 8'h00;
        endcase
    end

    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            state_q     <= S_IDLE;
            seq_q       <= 4'd0;
            last_snap_q <= '0;
            snap_lat_q  <= '0;
            delta_q     <= 8'd0;
            ts_q        <= 8'd0;
            ovf_q       <= 1'b0;
            ovf_lat_q   <= 1'b0;
            force_q     <= 1'b1;
            en_prev_q   <= 1'b0;
            drop_q      <= 8'd0;
        end else begin
            en_prev_q <= trace_enable_i;

            if (w_event) begin
                delta_q <= 8'd1;
            end else if (delta_q != 8'hFF) begin
                delta_q <= delta_q + 8'd1;
            end

            // An event consumes a pending enable edge, so it never yields a second sync packet.
            if (w_event) begin
                force_q     <= 1'b0;
                last_snap_q <= w_snap;
                if (w_room) begin
                    snap_lat_q <= w_snap;
                    ts_q       <= delta_q;
                    ovf_lat_q  <= ovf_q;
                    state_q    <= S_W0;
                end else begin
                    ovf_q <= 1'b1;
                    if (drop_q != 8'hFF) begin
                        drop_q <= drop_q + 8'd1;
                    end
                end
            end else if (w_en_rise) begin
                force_q <= 1'b1;
            end

            unique case (state_q)
                S_W0: state_q <= S_W1;
                S_W1: state_q <= S_W2;
                S_W2: state_q <= S_W3;
                S_W3: state_q <= S_W4;
                S_W4: begin
                    state_q <= S_IDLE;
                    seq_q   <= seq_q + 4'd1;
                    if (ovf_lat_q) begin
                        ovf_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        level_d = level_q + LVL_W'(w_push) - LVL_W'(w_pop);
    end

    always_ff @(posedge PCLK_i or posedge PRESET_i) begin
        if (PRESET_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_q] <= w_byte;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    assign trace_data_o  = mem_q[rd_q];
    assign trace_valid_o = (level_q != '0);
    assign fifo_level_o  = level_q;
    assign drop_count_o  = drop_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sd_trace_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_trace_packetizer
//  Purpose  : Directed, table-driven bench for the trace packetizer.
//  Revision : 1.0  initial release
// ============================================================================

module tb_sd_trace_packetizer;

    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             en;
    logic             cmd, data, dma;
    logic [15:0]      err;
    logic [1:0]       pwr;
    logic [7:0]       tdata;
    logic             tvalid;
    logic             tready;
    logic [7:0]       drops;
    logic [LVL_W-1:0] level;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    sd_trace_packetizer #(.FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
        .PCLK_i         (clk),
        .PRESET_i       (rst),
        .trace_enable_i (en),
        .cmd_busy_i     (cmd),
        .data_busy_i    (data),
        .dma_busy_i     (dma),
        .error_status_i (err),
        .power_state_i  (pwr),
        .trace_data_o   (tdata),
        .trace_valid_o  (tvalid),
        .trace_ready_i  (tready),
        .drop_count_o   (drops),
        .fifo_level_o   (level),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every byte handed over: ready only changes just after a rising edge.
    always @(negedge clk) begin
        if (!rst && tvalid && tready) got_q.push_back(tdata);
    end

    typedef struct {
        logic        c_cmd;
        logic        c_data;
        logic        c_dma;
        logic [15:0] c_err;
        logic [1:0]  c_pwr;
        int          pre;
        logic        has_pkt;
        logic [39:0] pkt;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic c, input logic d, input logic m,
                          input logic [15:0] e, input logic [1:0] p);
        cmd  = c;
        data = d;
        dma  = m;
        err  = e;
        pwr  = p;
    endtask

    task automatic push_pkt(input logic [39:0] p);
        for (int i = 0; i < 5; i++) exp_q.push_back(p[39-8*i -: 8]);
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 0,   1'b1, 40'hA1_01_00_00_08};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 0,   1'b1, 40'hA2_00_00_00_08};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 16'h8001, 2'd2, 0,   1'b1, 40'hA3_10_80_01_08};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h8001, 2'd2, 0,   1'b0, 40'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h8001, 2'd2, 300, 1'b1, 40'hA4_12_80_01_FF};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'd3, 0,   1'b1, 40'hA5_1C_00_00_08};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h1234, 2'd1, 0,   1'b1, 40'hA6_0B_12_34_08};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 0,   1'b1, 40'hA7_00_00_00_08};

        rst    = 1'b1;
        en     = 1'b1;
        tready = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
        step(3);
        @(negedge clk);
        chk("rst_valid", 32'(tvalid), 32'd0);
        chk("rst_data",  32'(tdata),  32'd0);
        chk("rst_drops", 32'(drops),  32'd0);
        chk("rst_level", 32'(level),  32'd0);
        chk("rst_busy",  32'(busy),   32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        step(8);
        push_pkt(40'hA0_00_00_00_00);
        cmp_stream("sync");
        chk("sync_idle_valid", 32'(tvalid), 32'd0);

        for (int k = 0; k < 8; k++) begin
            if (tbl[k].pre > 0) step(tbl[k].pre);
            set_in(tbl[k].c_cmd, tbl[k].c_data, tbl[k].c_dma, tbl[k].c_err, tbl[k].c_pwr);
            step(8);
            if (tbl[k].has_pkt) push_pkt(tbl[k].pkt);
            cmp_stream($sformatf("vec%0d", k));
        end

        // Short pulse: the fall lands mid-packet and is reported after W4.
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
        step(3);
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
        step(12);
        push_pkt(40'hA8_01_00_00_08);
        push_pkt(40'hA9_00_00_00_06);
        cmp_stream("pulse");

        // Change and revert while busy: only the first change is reported.
        set_in(1'b0, 1'b0, 1'b1, 16'h0, 2'd0);
        step(2);
        chk("busy_mid", 32'(busy), 32'd1);
        set_in(1'b0, 1'b0, 1'b1, 16'hFFFF, 2'd0);
        step(2);
        set_in(1'b0, 1'b0, 1'b1, 16'h0, 2'd0);
        step(12);
        push_pkt(40'hAA_04_00_00_09);
        cmp_stream("revert");

        // Overflow: three packets fit, the fourth is dropped.
        tready = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 2'd0); step(8);
        set_in(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); step(8);
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 2'd0); step(8);
        chk("ovf_level3", 32'(level), 32'd15);
        chk("ovf_drops0", 32'(drops), 32'd0);
        set_in(1'b0, 1'b0, 1'b1, 16'h0, 2'd0); step(8);
        chk("ovf_level", 32'(level), 32'd15);
        chk("ovf_drops", 32'(drops), 32'd1);
        chk("ovf_busy",  32'(busy),  32'd0);
        tready = 1'b1;
        step(20);
        set_in(1'b0, 1'b0, 1'b1, 16'h00AA, 2'd0); step(8);
        set_in(1'b0, 1'b0, 1'b1, 16'h0000, 2'd0); step(8);
        set_in(1'b0, 1'b0, 1'b0, 16'h0000, 2'd0); step(8);
        push_pkt(40'hAB_00_00_00_10);
        push_pkt(40'hAC_04_00_00_08);
        push_pkt(40'hAD_00_00_00_08);
        push_pkt(40'hAE_84_00_AA_1C);
        push_pkt(40'hAF_04_00_00_08);
        push_pkt(40'hA0_00_00_00_08);
        cmp_stream("ovf_wrap");
        chk("ovf_drops_hold", 32'(drops), 32'd1);

        // Enable toggle with static inputs yields exactly one sync packet.
        en = 1'b0;
        step(4);
        en = 1'b1;
        step(10);
        push_pkt(40'hA1_00_00_00_0C);
        cmp_stream("en_sync");

        // Reset in the middle of a packet.
        tready = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
        step(3);
        chk("mid_level", 32'(level), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(tvalid), 32'd0);
        chk("mid_rst_data",  32'(tdata),  32'd0);
        chk("mid_rst_level", 32'(level),  32'd0);
        chk("mid_rst_drops", 32'(drops),  32'd0);
        chk("mid_rst_busy",  32'(busy),   32'd0);
        tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step(8);
        push_pkt(40'hA0_01_00_00_00);
        cmp_stream("post_rst");
        chk("end_valid", 32'(tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
